// File: rtl/pci_target_mem_if.sv
// PCI target bus bundle: FRAME#/IRDY#/C/BE#/DEVSEL#/TRDY#/STOP# plus the shared AD net.
// The target and master each present a data/enable pair, and the interface resolves them onto AD.
interface pci_target_mem_if;
    logic        Frame;
    logic        IRDY;
    logic [3:0]  CBE;
    logic        DEVSEL;
    logic        TRDY;
    logic        STOP;
    logic [31:0] o_ad_data;
    logic        o_ad_oe;
    logic [31:0] m_ad_data;
    logic        m_ad_oe;
    wire  [31:0] AD;

    // The target's enable takes priority; the protocol keeps the two enables from overlapping.
    assign AD = o_ad_oe ? o_ad_data : (m_ad_oe ? m_ad_data : {32{1'bz}});

    modport master (
        output Frame, IRDY, CBE, m_ad_data, m_ad_oe,
        input  AD, DEVSEL, TRDY, STOP, o_ad_oe
    );

    modport slave (
        input  Frame, IRDY, CBE, AD,
        output DEVSEL, TRDY, STOP, o_ad_data, o_ad_oe
    );
endinterface

// File: rtl/pci_target_mem.sv
// PCI memory target with a DEPTH-dword local memory, linear wrapping bursts and programmable wait states.
// Define PCI_DISCONNECT_EN to enable disconnect at the top of the window instead of wrapping.
module pci_target_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0010,
    parameter int          DEPTH       = 4,
    parameter int          WAIT_STATES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pci_target_mem_if.slave            bus,
    output logic [$clog2(DEPTH)-1:0]   dbg_index
);
    localparam int IW = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_IGNORE = 3'd3;
`ifdef PCI_DISCONNECT_EN
    localparam logic [2:0] S_STOP   = 3'd4;
`endif

    localparam logic [3:0] CMD_MRD = 4'b0010;
    localparam logic [3:0] CMD_MWR = 4'b0011;

    logic [2:0]    r_state;
    logic          r_isRead;
    logic [IW-1:0] r_index;
    logic [3:0]    r_waitCnt;
    logic          r_devsel;
    logic          r_trdy;
    logic [31:0]   r_mem [DEPTH];

    logic          w_isRead;
    logic          w_hit;
    logic          w_xfer;
    logic          w_abort;
    logic [3:0]    w_waitTotal;

    assign w_isRead    = (bus.CBE == CMD_MRD);
    assign w_hit       = (bus.AD[31:IW+2] == BASE_ADDR[31:IW+2]) && (w_isRead || (bus.CBE == CMD_MWR));
    assign w_xfer      = (r_state == S_DATA) && !bus.IRDY && !r_trdy;
    assign w_abort     = bus.Frame && bus.IRDY;
    // Reads spend one extra cycle in WAIT so the master can turn AD around.
    assign w_waitTotal = 4'(WAIT_STATES) + {3'b000, w_isRead};

`ifdef PCI_DISCONNECT_EN
    logic r_stop;
    logic w_lastIdx;
    assign w_lastIdx = (r_index == IW'(DEPTH - 1));
    assign bus.STOP  = r_stop;
`else
    assign bus.STOP  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_isRead  <= 1'b0;
            r_index   <= '0;
            r_waitCnt <= '0;
            r_devsel  <= 1'b1;
            r_trdy    <= 1'b1;
`ifdef PCI_DISCONNECT_EN
            r_stop    <= 1'b1;
`endif
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.Frame) begin
                        if (w_hit) begin
                            r_isRead <= w_isRead;
                            r_index  <= bus.AD[IW+1:2];
                            r_devsel <= 1'b0;
                            if (w_waitTotal == 4'd0) begin
                                r_trdy  <= 1'b0;
                                r_state <= S_DATA;
                            end else begin
                                r_waitCnt <= w_waitTotal;
                                r_state   <= S_WAIT;
                            end
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                end
                S_IGNORE: begin
                    if (w_abort) r_state <= S_IDLE;
                end
                S_WAIT: begin
                    if (w_abort) begin
                        r_devsel <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (r_waitCnt == 4'd1) begin
                        r_trdy  <= 1'b0;
                        r_state <= S_DATA;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        for (int i = 0; i < 4; i++) begin
                            if (!r_isRead && !bus.CBE[i]) r_mem[r_index][8*i +: 8] <= bus.AD[8*i +: 8];
                        end
                        r_index <= r_index + 1'b1;
                        if (bus.Frame) begin
                            r_devsel <= 1'b1;
                            r_trdy   <= 1'b1;
                            r_state  <= S_IDLE;
                        end
`ifdef PCI_DISCONNECT_EN
                        // TRDY is released alongside STOP so nothing past the window top can move.
                        else if (w_lastIdx) begin
                            r_stop  <= 1'b0;
                            r_trdy  <= 1'b1;
                            r_state <= S_STOP;
                        end
`endif
                    end else if (w_abort) begin
                        r_devsel <= 1'b1;
                        r_trdy   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
`ifdef PCI_DISCONNECT_EN
                S_STOP: begin
                    if (bus.Frame) begin
                        r_stop   <= 1'b1;
                        r_devsel <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.DEVSEL    = r_devsel;
    assign bus.TRDY      = r_trdy;
    assign bus.o_ad_oe   = (r_state == S_DATA) && r_isRead && !r_trdy;
    assign bus.o_ad_data = r_mem[r_index];
    assign dbg_index     = r_index;
endmodule

// File: tb/tb_pci_target_mem.sv
// Directed bench for pci_target_mem: one instance with no wait states, one with three.
// Every expected value below is hand-derived from the bus protocol timing.
module tb_pci_target_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pci_target_mem_if bus0 ();
    pci_target_mem_if bus3 ();
    logic [1:0] dbgIndex0;
    logic [1:0] dbgIndex3;

    int vecCount = 0;
    int missCount = 0;

    pci_target_mem #(.BASE_ADDR(32'h0000_0010), .DEPTH(4), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_index(dbgIndex0)
    );
    pci_target_mem #(.BASE_ADDR(32'h0000_0010), .DEPTH(4), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .dbg_index(dbgIndex3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle0;
        bus0.Frame = 1'b1; bus0.IRDY = 1'b1; bus0.CBE = 4'hF; bus0.m_ad_oe = 1'b0; bus0.m_ad_data = '0;
    endtask

    task automatic idle3;
        bus3.Frame = 1'b1; bus3.IRDY = 1'b1; bus3.CBE = 4'hF; bus3.m_ad_oe = 1'b0; bus3.m_ad_data = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle0;
        idle3;
        tick;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1) begin missCount++; $display("[TB] FAIL reset_devsel: got %b want 1", bus0.DEVSEL); end
        vecCount++; if (bus0.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL reset_trdy: got %b want 1", bus0.TRDY); end
        vecCount++; if (bus0.STOP !== 1'b1) begin missCount++; $display("[TB] FAIL reset_stop: got %b want 1", bus0.STOP); end
        vecCount++; if (bus0.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ad_oe: got %b want 0", bus0.o_ad_oe); end
        vecCount++; if (dbgIndex0 !== 2'd0) begin missCount++; $display("[TB] FAIL reset_index: got %0d want 0", dbgIndex0); end
        vecCount++; if (bus3.DEVSEL !== 1'b1) begin missCount++; $display("[TB] FAIL reset_devsel3: got %b want 1", bus3.DEVSEL); end
        rst_n = 1'b1;
        tick;
    endtask

    // Partial-lane write to dword 1 followed immediately by a read-back.
    task automatic test_byte_enables;
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0011; bus0.m_ad_oe = 1'b1; bus0.m_ad_data = 32'h14;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b0) begin missCount++; $display("[TB] FAIL be_devsel: got %b want 0", bus0.DEVSEL); end
        vecCount++; if (bus0.TRDY !== 1'b0) begin missCount++; $display("[TB] FAIL be_trdy: got %b want 0", bus0.TRDY); end
        vecCount++; if (dbgIndex0 !== 2'd1) begin missCount++; $display("[TB] FAIL be_index: got %0d want 1", dbgIndex0); end
        bus0.Frame = 1'b1; bus0.IRDY = 1'b0; bus0.CBE = 4'b1010; bus0.m_ad_data = 32'hAABB_CCDD;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1) begin missCount++; $display("[TB] FAIL be_done_devsel: got %b want 1", bus0.DEVSEL); end
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0010; bus0.m_ad_data = 32'h14;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b0) begin missCount++; $display("[TB] FAIL b2b_devsel: got %b want 0", bus0.DEVSEL); end
        vecCount++; if (bus0.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL b2b_turnaround_trdy: got %b want 1", bus0.TRDY); end
        vecCount++; if (bus0.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL b2b_turnaround_oe: got %b want 0", bus0.o_ad_oe); end
        bus0.m_ad_oe = 1'b0; bus0.Frame = 1'b1; bus0.IRDY = 1'b0; bus0.CBE = 4'b0000;
        tick;
        vecCount++; if (bus0.TRDY !== 1'b0) begin missCount++; $display("[TB] FAIL be_rd_trdy: got %b want 0", bus0.TRDY); end
        vecCount++; if (bus0.AD !== 32'h00BB_00DD) begin missCount++; $display("[TB] FAIL be_rd_data: got %h want 00bb00dd", bus0.AD); end
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1 || bus0.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL be_rd_done: got devsel=%b trdy=%b want 1/1", bus0.DEVSEL, bus0.TRDY); end
        vecCount++; if (bus0.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL be_rd_release: got oe=%b want 0", bus0.o_ad_oe); end
        idle0;
        tick;
    endtask

    task automatic test_write_burst;
        logic [31:0] wdata [4];
        wdata[0] = 32'h1001; wdata[1] = 32'h1002; wdata[2] = 32'h1003; wdata[3] = 32'h1004;
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0011; bus0.m_ad_oe = 1'b1; bus0.m_ad_data = 32'h10;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b0 || bus0.TRDY !== 1'b0) begin missCount++; $display("[TB] FAIL wb_start: got devsel=%b trdy=%b want 0/0", bus0.DEVSEL, bus0.TRDY); end
        bus0.IRDY = 1'b0; bus0.CBE = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus0.m_ad_data = wdata[i];
            if (i == 3) bus0.Frame = 1'b1;
            tick;
            if (i < 3) begin
                vecCount++; if (dbgIndex0 !== 2'(i + 1)) begin missCount++; $display("[TB] FAIL wb_index%0d: got %0d want %0d", i, dbgIndex0, i + 1); end
            end
        end
        vecCount++; if (bus0.DEVSEL !== 1'b1 || bus0.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL wb_done: got devsel=%b trdy=%b want 1/1", bus0.DEVSEL, bus0.TRDY); end
        idle0;
        tick;
    endtask

    // Read from dword 2 wraps through 3, 0, 1 with one master stall after the second word.
    task automatic test_read_burst;
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0010; bus0.m_ad_oe = 1'b1; bus0.m_ad_data = 32'h18;
        #1;
        vecCount++; if (bus0.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL rb_addr_oe: got %b want 0", bus0.o_ad_oe); end
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b0 || bus0.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL rb_turnaround: got devsel=%b trdy=%b want 0/1", bus0.DEVSEL, bus0.TRDY); end
        vecCount++; if (bus0.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL rb_turnaround_oe: got %b want 0", bus0.o_ad_oe); end
        bus0.m_ad_oe = 1'b0; bus0.IRDY = 1'b0; bus0.CBE = 4'b0000;
        tick;
        vecCount++; if (bus0.TRDY !== 1'b0 || bus0.AD !== 32'h1003) begin missCount++; $display("[TB] FAIL rb_word0: got trdy=%b ad=%h want 0/00001003", bus0.TRDY, bus0.AD); end
        vecCount++; if (dbgIndex0 !== 2'd2) begin missCount++; $display("[TB] FAIL rb_index0: got %0d want 2", dbgIndex0); end
        tick;
        vecCount++; if (bus0.AD !== 32'h1004 || dbgIndex0 !== 2'd3) begin missCount++; $display("[TB] FAIL rb_word1: got ad=%h idx=%0d want 00001004/3", bus0.AD, dbgIndex0); end
        bus0.IRDY = 1'b1;
        tick;
        vecCount++; if (bus0.AD !== 32'h1004 || dbgIndex0 !== 2'd3) begin missCount++; $display("[TB] FAIL rb_stall: got ad=%h idx=%0d want 00001004/3", bus0.AD, dbgIndex0); end
        vecCount++; if (bus0.TRDY !== 1'b0) begin missCount++; $display("[TB] FAIL rb_stall_trdy: got %b want 0", bus0.TRDY); end
        bus0.IRDY = 1'b0;
        tick;
        vecCount++; if (bus0.AD !== 32'h1001 || dbgIndex0 !== 2'd0) begin missCount++; $display("[TB] FAIL rb_wrap: got ad=%h idx=%0d want 00001001/0", bus0.AD, dbgIndex0); end
        tick;
        vecCount++; if (bus0.AD !== 32'h1002 || dbgIndex0 !== 2'd1) begin missCount++; $display("[TB] FAIL rb_word3: got ad=%h idx=%0d want 00001002/1", bus0.AD, dbgIndex0); end
        bus0.Frame = 1'b1;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1 || bus0.TRDY !== 1'b1 || bus0.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL rb_done: got devsel=%b trdy=%b oe=%b want 1/1/0", bus0.DEVSEL, bus0.TRDY, bus0.o_ad_oe); end
        idle0;
        tick;
    endtask

    task automatic test_ignore;
        // Out-of-window write; its second data phase looks like an in-window address and must not be decoded.
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0011; bus0.m_ad_oe = 1'b1; bus0.m_ad_data = 32'h40;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1 || bus0.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL ign_addr: got devsel=%b trdy=%b want 1/1", bus0.DEVSEL, bus0.TRDY); end
        bus0.IRDY = 1'b0; bus0.CBE = 4'b0000; bus0.m_ad_data = 32'hDEAD_BEEF;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1 || bus0.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL ign_data: got devsel=%b oe=%b want 1/0", bus0.DEVSEL, bus0.o_ad_oe); end
        bus0.CBE = 4'b0011; bus0.m_ad_data = 32'h10;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1 || bus0.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL ign_redecode: got devsel=%b trdy=%b want 1/1", bus0.DEVSEL, bus0.TRDY); end
        bus0.Frame = 1'b1; bus0.CBE = 4'b0000; bus0.m_ad_data = 32'hDEAD_BEEF;
        tick;
        idle0;
        tick;
        // Unsupported command inside the window.
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0110; bus0.m_ad_oe = 1'b1; bus0.m_ad_data = 32'h10;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1) begin missCount++; $display("[TB] FAIL ign_cmd: got devsel=%b want 1", bus0.DEVSEL); end
        bus0.Frame = 1'b1; bus0.IRDY = 1'b0; bus0.CBE = 4'b0000; bus0.m_ad_data = 32'hDEAD_BEEF;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1 || bus0.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL ign_cmd_data: got devsel=%b oe=%b want 1/0", bus0.DEVSEL, bus0.o_ad_oe); end
        idle0;
        tick;
        // A valid read of dword 0 still decodes and shows the burst value.
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0010; bus0.m_ad_oe = 1'b1; bus0.m_ad_data = 32'h10;
        tick;
        bus0.m_ad_oe = 1'b0; bus0.Frame = 1'b1; bus0.IRDY = 1'b0; bus0.CBE = 4'b0000;
        tick;
        vecCount++; if (bus0.TRDY !== 1'b0 || bus0.AD !== 32'h1001) begin missCount++; $display("[TB] FAIL ign_after_read: got trdy=%b ad=%h want 0/00001001", bus0.TRDY, bus0.AD); end
        tick;
        idle0;
        tick;
    endtask

    task automatic test_wait_states;
        int waited;
        bus3.Frame = 1'b0; bus3.IRDY = 1'b1; bus3.CBE = 4'b0011; bus3.m_ad_oe = 1'b1; bus3.m_ad_data = 32'h10;
        tick;
        vecCount++; if (bus3.DEVSEL !== 1'b0 || bus3.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL ws_wr_addr: got devsel=%b trdy=%b want 0/1", bus3.DEVSEL, bus3.TRDY); end
        bus3.Frame = 1'b1; bus3.IRDY = 1'b0; bus3.CBE = 4'b0000; bus3.m_ad_data = 32'h5A5A_1234;
        waited = 1;
        while (bus3.TRDY !== 1'b0 && waited < 12) begin tick; waited++; end
        vecCount++; if (waited !== 4) begin missCount++; $display("[TB] FAIL ws_wr_latency: got %0d cycles want 4", waited); end
        tick;
        vecCount++; if (bus3.DEVSEL !== 1'b1) begin missCount++; $display("[TB] FAIL ws_wr_done: got devsel=%b want 1", bus3.DEVSEL); end
        bus3.Frame = 1'b0; bus3.IRDY = 1'b1; bus3.CBE = 4'b0010; bus3.m_ad_oe = 1'b1; bus3.m_ad_data = 32'h10;
        tick;
        bus3.m_ad_oe = 1'b0; bus3.Frame = 1'b1; bus3.IRDY = 1'b0; bus3.CBE = 4'b0000;
        waited = 1;
        while (bus3.TRDY !== 1'b0 && waited < 12) begin
            vecCount++; if (bus3.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL ws_rd_early_drive: got oe=%b at cycle %0d want 0", bus3.o_ad_oe, waited); end
            tick;
            waited++;
        end
        vecCount++; if (waited !== 5) begin missCount++; $display("[TB] FAIL ws_rd_latency: got %0d cycles want 5", waited); end
        vecCount++; if (bus3.AD !== 32'h5A5A_1234) begin missCount++; $display("[TB] FAIL ws_rd_data: got %h want 5a5a1234", bus3.AD); end
        tick;
        vecCount++; if (bus3.DEVSEL !== 1'b1 || bus3.o_ad_oe !== 1'b0) begin missCount++; $display("[TB] FAIL ws_rd_done: got devsel=%b oe=%b want 1/0", bus3.DEVSEL, bus3.o_ad_oe); end
        idle3;
        tick;
    endtask

    task automatic test_reset_abort;
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0011; bus0.m_ad_oe = 1'b1; bus0.m_ad_data = 32'h10;
        tick;
        bus0.IRDY = 1'b0; bus0.CBE = 4'b0000; bus0.m_ad_data = 32'h1111_1111;
        tick;
        bus0.m_ad_data = 32'h2222_2222;
        rst_n = 1'b0;
        tick;
        vecCount++; if (bus0.DEVSEL !== 1'b1 || bus0.TRDY !== 1'b1) begin missCount++; $display("[TB] FAIL rst_abort_bus: got devsel=%b trdy=%b want 1/1", bus0.DEVSEL, bus0.TRDY); end
        vecCount++; if (dbgIndex0 !== 2'd0) begin missCount++; $display("[TB] FAIL rst_abort_index: got %0d want 0", dbgIndex0); end
        rst_n = 1'b1;
        idle0;
        tick;
        bus0.Frame = 1'b0; bus0.IRDY = 1'b1; bus0.CBE = 4'b0010; bus0.m_ad_oe = 1'b1; bus0.m_ad_data = 32'h10;
        tick;
        bus0.m_ad_oe = 1'b0; bus0.IRDY = 1'b0; bus0.CBE = 4'b0000;
        tick;
        for (int i = 0; i < 4; i++) begin
            vecCount++;
            if (bus0.o_ad_oe !== 1'b1 || bus0.AD !== 32'h0 || dbgIndex0 !== 2'(i)) begin
                missCount++;
                $display("[TB] FAIL rst_mem%0d: got oe=%b ad=%h idx=%0d want 1/00000000/%0d", i, bus0.o_ad_oe, bus0.AD, dbgIndex0, i);
            end
            if (i == 3) bus0.Frame = 1'b1;
            tick;
        end
        vecCount++; if (bus0.DEVSEL !== 1'b1) begin missCount++; $display("[TB] FAIL rst_read_done: got devsel=%b want 1", bus0.DEVSEL); end
        idle0;
        tick;
    endtask

    initial begin
        test_reset;
        test_byte_enables;
        test_write_burst;
        test_read_burst;
        test_ignore;
        test_wait_states;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end
endmodule
